uc_pila: RTL
============

# uc_pila

Parametrised control unit with integrated program-counter sequencer and a return-address stack for the single-cycle CPU. It decodes the 6-bit opcode, drives the datapath enables and ALU operation, and owns the PC register. It adds subroutine call/return, halt, and a run/halt/fault state machine. It replaces the purely combinational control unit plus external PC mux in the CPU top level.

## Interface
- `PC_W`, 10, program-counter and jump-address width.
- `DEPTH`, 4, return-stack entries; power of two, 2..16.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction bits [15:10].
- `z`  in  1  registered zero flag from the datapath.
- `jump_addr`  in  PC_W  target address field of the instruction.
- `pc`  out  PC_W  current instruction address (registered).
- `s_inm`  out  1  select immediate into the register-file write port.
- `we3`  out  1  register-file write enable.
- `wez`  out  1  zero-flag write enable.
- `op_alu`  out  3  ALU operation.
- `halted`  out  1  state is HALT.
- `fault`  out  1  state is FAULT (stack error).

## Operation
- Decode, by opcode:
  - `0xxxxx` ALU: op_alu=opcode[4:2], we3=1, wez=1, pc<=pc+1.
  - `11xxxx` LI: s_inm=1, we3=1, pc<=pc+1.
  - `100000` J: pc<=jump_addr.
  - `100010` JZ: pc<=jump_addr if z=1, else pc+1.
  - `100011` JNZ: pc<=jump_addr if z=0, else pc+1.
  - `100100` JAL: push pc+1, pc<=jump_addr.
  - `100101` RET: pop, pc<=popped value.
  - `100110` HLT: state<=HALT, pc holds.
  - any other `10xxxx`: NOP, pc<=pc+1.
- Non-ALU opcodes drive op_alu=000, we3=0, wez=0, s_inm=0 unless listed.
- Stack:
  - Array of DEPTH×PC_W entries with stack pointer `sp` (0..DEPTH) counting occupied entries.
  - Push writes entry[sp] and increments sp.
  - Pop reads entry[sp-1] and decrements sp.
- States:
  - RUN: decode normally.
  - HALT: all enables 0, op_alu=000, pc and sp frozen. Left only via reset.
  - FAULT: same outputs as HALT. Entered only when UC_STACK_ERR_EN is defined.
- PC arithmetic is modulo 2^PC_W; pc+1 at all-ones wraps to 0.

## Timing
- Control outputs are combinational from opcode, z and state in the same cycle.
- pc, sp, stack and state update on the next rising clk edge. One instruction per cycle; zero-latency decode.
- Reset (asynchronous, reset=0):
  - pc=0, sp=0, state=RUN, halted=0, fault=0.
  - Stack contents are don't-care.
  - Control outputs follow the opcode decode in RUN.
- Reset asserted mid-cycle aborts any pending push/pop. Release is synchronous to the next edge.
- Push when sp=DEPTH (full) and pop when sp=0 (empty): behaviour per Configuration.
- Conditional jumps read z as presented in the current cycle. The datapath guarantees z reflects the previous wez=1 instruction.

## Configuration
- `UC_STACK_ERR_EN` defined:
  - JAL on full or RET on empty: no stack change, pc holds, state<=FAULT, fault=1 from the next cycle until reset.
- `UC_STACK_ERR_EN` undefined:
  - JAL on full: the return address is discarded, sp stays DEPTH, pc<=jump_addr.
  - RET on empty: treated as NOP, pc<=pc+1.
  - fault is tied to 0 and FAULT is unreachable.

## Test plan
- Reset, then opcode `000100` (ALU op 001) for 3 cycles -> op_alu=001, we3=1, wez=1; pc steps 0,1,2,3.
- pc=5, JZ to 0x040 with z=1 -> pc=0x040 next cycle. Same with z=0 -> pc=6. JNZ gives the inverse results.
- JAL 0x100 at pc=7, then JAL 0x200 at 0x100, then RET, RET -> pc sequence 0x100, 0x200, 0x101, 0x008; sp returns to 0.
- With UC_STACK_ERR_EN: DEPTH+1 consecutive JALs -> fault=1 after the (DEPTH+1)th, pc frozen, we3=0. Then reset=0 -> pc=0, fault=0.
- Without the macro: RET at pc=3 with sp=0 -> pc=4, fault stays 0.
- HLT at pc=9 -> halted=1, pc stays 9 for 10 cycles with all enables 0. Asserting reset asynchronously mid-cycle -> pc=0 immediately.

Source files
------------

// File: rtl/uc_pila.sv
// Control unit with PC sequencer and return-address stack for the single-cycle CPU.
// Optional feature: define UC_STACK_ERR_EN to trap stack overflow/underflow into FAULT.
module uc_pila #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic            z,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [2:0]      op_alu,
    output logic            halted,
    output logic            fault
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SP_W = $clog2(DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t            state, state_next;
    logic [SP_W-1:0]   sp;
    logic [PC_W-1:0]   stack [DEPTH];
    logic [PC_W-1:0]   pc_next, pc_inc, top;
    logic [AW-1:0]     top_idx;
    logic              push, pop, full, empty;

    assign pc_inc  = pc + PC_W'(1);
    assign full    = (sp == SP_FULL);
    assign empty   = (sp == '0);
    assign top_idx = AW'(sp - SP_W'(1));
    assign top     = stack[top_idx];

    assign halted = (state == HALT);
`ifdef UC_STACK_ERR_EN
    assign fault  = (state == FAULT);
`else
    assign fault  = 1'b0;
`endif

    always_comb begin
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op_alu     = '0;
        pc_next    = pc;
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        if (state == RUN) begin
            casez (opcode)
                6'b0?????: begin
                    op_alu  = opcode[4:2];
                    we3     = 1'b1;
                    wez     = 1'b1;
                    pc_next = pc_inc;
                end
                6'b11????: begin
                    s_inm   = 1'b1;
                    we3     = 1'b1;
                    pc_next = pc_inc;
                end
                6'b100000: pc_next = jump_addr;
                6'b100010: pc_next = z ? jump_addr : pc_inc;
                6'b100011: pc_next = z ? pc_inc : jump_addr;
                6'b100100: begin
`ifdef UC_STACK_ERR_EN
                    if (full) begin
                        state_next = FAULT;
                    end else begin
                        push    = 1'b1;
                        pc_next = jump_addr;
                    end
`else
                    // A full stack silently drops the return address.
                    push    = !full;
                    pc_next = jump_addr;
`endif
                end
                6'b100101: begin
                    if (empty) begin
`ifdef UC_STACK_ERR_EN
                        state_next = FAULT;
`else
                        pc_next = pc_inc;
`endif
                    end else begin
                        pop     = 1'b1;
                        pc_next = top;
                    end
                end
                6'b100110: state_next = HALT;
                default:   pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            sp    <= '0;
            state <= RUN;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            pc    <= pc_next;
            state <= state_next;
            if (push) begin
                stack[AW'(sp)] <= pc_inc;
                sp             <= sp + SP_W'(1);
            end else if (pop) begin
                sp <= sp - SP_W'(1);
            end
        end
    end

endmodule
